// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/redirect controller for a 5-stage pipeline (pc, if_id, id_ex, ex_mem, mem_wb).
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_stallreq_if/id/mem    stall requests from fetch, decode (load-use), data memory
//   i_br_taken_ex/target_ex taken branch resolved in EX and its target
//   o_stall[5:0]            hold per stage: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
//   o_flush_if_id/id_ex     load NOP into if_id / id_ex next edge
//   o_pc_redirect/pc        pc loads o_redirect_pc next edge
//   o_redirect_pend         a redirect is parked behind a memory stall
//   o_cnt_stall/flush       saturating counts of stall cycles / redirects issued
//   o_hang_err              sticky: stallreq_mem held MEM_TIMEOUT consecutive cycles
module pipe_ctrl #(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stallreq_if,
  input  logic             i_stallreq_id,
  input  logic             i_stallreq_mem,
  input  logic             i_br_taken_ex,
  input  logic [PC_W-1:0]  i_br_target_ex,
  output logic [5:0]       o_stall,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic             o_pc_redirect,
  output logic [PC_W-1:0]  o_redirect_pc,
  output logic             o_redirect_pend,
  output logic [CNT_W-1:0] o_cnt_stall,
  output logic [CNT_W-1:0] o_cnt_flush,
  output logic             o_hang_err
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] PEND = 1'b1;
  logic [0:0]       r_state;
  logic [PC_W-1:0]  r_pend_pc;
  logic [TW-1:0]    r_tcnt;
  logic [CNT_W-1:0] r_cnt_stall;
  logic [CNT_W-1:0] r_cnt_flush;
  logic             r_hang;
  logic             w_pend;
  logic             w_redir;
  logic             w_capture;
  logic [TW-1:0]    w_tnext;
  // Outputs are gated by i_rst_n so everything reads 0 while reset is held.
  // A memory stall freezes EX, so any redirect (live or parked) waits for it to end.
  always_comb begin
    w_pend          = i_rst_n && r_state == PEND;
    w_redir         = i_rst_n && !i_stallreq_mem && (w_pend || i_br_taken_ex);
    w_capture       = i_rst_n && !w_pend && i_stallreq_mem && i_br_taken_ex;
    o_stall         = (!i_rst_n || w_redir) ? 6'h00 :
                      i_stallreq_mem ? 6'h1F :
                      i_stallreq_id  ? 6'h07 :
                      i_stallreq_if  ? 6'h03 : 6'h00;
    o_pc_redirect   = w_redir;
    o_flush_if_id   = w_redir;
    o_flush_id_ex   = w_redir;
    o_redirect_pc   = !w_redir ? '0 : w_pend ? r_pend_pc : i_br_target_ex;
    o_redirect_pend = w_pend;
    o_cnt_stall     = r_cnt_stall;
    o_cnt_flush     = r_cnt_flush;
    o_hang_err      = r_hang;
    w_tnext         = !i_stallreq_mem ? '0 : r_tcnt == TMAX ? TMAX : r_tcnt + 1'b1;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= RUN;
      r_pend_pc   <= '0;
      r_tcnt      <= '0;
      r_cnt_stall <= '0;
      r_cnt_flush <= '0;
      r_hang      <= 1'b0;
    end else begin
      r_state     <= w_capture ? PEND : w_redir ? RUN : r_state;
      r_pend_pc   <= w_capture ? i_br_target_ex : r_pend_pc;
      r_tcnt      <= w_tnext;
      r_cnt_stall <= r_cnt_stall + CNT_W'(|o_stall && !(&r_cnt_stall));
      r_cnt_flush <= r_cnt_flush + CNT_W'(w_redir && !(&r_cnt_flush));
      r_hang      <= r_hang | (w_tnext == TMAX);
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed + model-checked bench for pipe_ctrl (CNT_W=4, MEM_TIMEOUT=4).
module tb_pipe_ctrl;
  localparam int CMAX = 15;
  localparam int TMO  = 4;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        sif = 0, sid = 0, smem = 0, br = 0;
  logic [31:0] tgt = 0;
  logic [5:0]  stall;
  logic        fl_ifid, fl_idex, redir, pend, hang;
  logic [31:0] rpc;
  logic [3:0]  cnt_s, cnt_f;
  int          checks = 0, failures = 0;
  logic        m_pend = 0;
  logic [31:0] m_pend_pc = 0;
  int          m_cs = 0, m_cf = 0, m_mrun = 0;
  logic        m_hang = 0;
  logic [5:0]  e_stall;
  logic        e_red, e_pend;
  logic [31:0] e_rpc;

  pipe_ctrl #(.PC_W(32), .CNT_W(4), .MEM_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_stallreq_if(sif), .i_stallreq_id(sid), .i_stallreq_mem(smem),
    .i_br_taken_ex(br), .i_br_target_ex(tgt),
    .o_stall(stall), .o_flush_if_id(fl_ifid), .o_flush_id_ex(fl_idex),
    .o_pc_redirect(redir), .o_redirect_pc(rpc), .o_redirect_pend(pend),
    .o_cnt_stall(cnt_s), .o_cnt_flush(cnt_f), .o_hang_err(hang)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // Expected combinational outputs from the priority rules.
  always_comb begin
    e_stall = '0;
    e_red   = 0;
    e_rpc   = '0;
    e_pend  = 0;
    if (rst_n) begin
      e_pend = m_pend;
      if (smem) e_stall = 6'h1F;
      else if (m_pend || br) begin
        e_red = 1;
        e_rpc = m_pend ? m_pend_pc : tgt;
      end
      else if (sid) e_stall = 6'h07;
      else if (sif) e_stall = 6'h03;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 0; m_pend_pc <= 0; m_cs <= 0; m_cf <= 0; m_mrun <= 0; m_hang <= 0;
    end else begin
      if (e_stall != 0) m_cs <= (m_cs >= CMAX) ? CMAX : m_cs + 1;
      if (e_red) m_cf <= (m_cf >= CMAX) ? CMAX : m_cf + 1;
      m_mrun <= smem ? ((m_mrun >= TMO) ? TMO : m_mrun + 1) : 0;
      m_hang <= m_hang || (smem && m_mrun >= TMO - 1);
      if (m_pend && !smem) m_pend <= 0;
      else if (!m_pend && smem && br) begin
        m_pend    <= 1;
        m_pend_pc <= tgt;
      end
    end
  end

  always @(negedge clk) begin
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush_if_id", 32'(fl_ifid), 32'(e_red));
    chk("flush_id_ex", 32'(fl_idex), 32'(e_red));
    chk("pc_redirect", 32'(redir), 32'(e_red));
    chk("redirect_pc", rpc, e_rpc);
    chk("redirect_pend", 32'(pend), 32'(e_pend));
    chk("cnt_stall", 32'(cnt_s), 32'(m_cs));
    chk("cnt_flush", 32'(cnt_f), 32'(m_cf));
    chk("hang_err", 32'(hang), 32'(m_hang));
  end

  task automatic cyc(input logic m, input logic b, input logic [31:0] t, input logic d, input logic f);
    @(posedge clk);
    #1;
    smem = m; br = b; tgt = t; sid = d; sif = f;
    @(negedge clk);
  endtask

  initial begin
    // reset with busy inputs
    for (int i = 0; i < 3; i++) begin
      cyc(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      chk("rst_stall", 32'(stall), 0);
      chk("rst_redirect", 32'(redir), 0);
    end
    cyc(1, 1, 32'h40, 1, 1);
    chk("rst_all_busy", 32'({stall, fl_ifid, fl_idex, redir, pend, hang}), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    smem = 0; br = 0; tgt = 0; sid = 0; sif = 0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("idle_cnt_stall", 32'(cnt_s), 0);
    // load-use stall
    cyc(0, 0, 0, 1, 0);
    chk("id_stall", 32'(stall), 32'h07);
    cyc(0, 0, 0, 0, 0);
    chk("id_cnt_stall", 32'(cnt_s), 1);
    chk("id_no_flush", 32'(fl_idex), 0);
    // branch overrides load-use
    cyc(0, 1, 32'h100, 1, 0);
    chk("br_redirect", 32'(redir), 1);
    chk("br_pc", rpc, 32'h100);
    chk("br_flushes", 32'({fl_ifid, fl_idex}), 32'h3);
    chk("br_stall", 32'(stall), 0);
    cyc(0, 0, 0, 0, 0);
    chk("br_cnt_flush", 32'(cnt_f), 1);
    // branch arriving during a memory stall is parked
    cyc(1, 1, 32'h200, 0, 0);
    chk("mem1_stall", 32'(stall), 32'h1F);
    chk("mem1_pend", 32'(pend), 0);
    cyc(1, 0, 0, 0, 0);
    chk("mem2_pend", 32'(pend), 1);
    cyc(1, 1, 32'h999, 0, 0);
    chk("mem3_ignore_br", 32'(redir), 0);
    chk("mem3_stall", 32'(stall), 32'h1F);
    cyc(0, 0, 0, 0, 0);
    chk("pend_redirect", 32'(redir), 1);
    chk("pend_pc", rpc, 32'h200);
    chk("pend_flushes", 32'({fl_ifid, fl_idex}), 32'h3);
    cyc(0, 0, 0, 0, 0);
    chk("pend_clear", 32'(pend), 0);
    chk("pend_cnt_flush", 32'(cnt_f), 2);
    chk("pend_cnt_stall", 32'(cnt_s), 4);
    // memory hang
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
    chk("hang_before", 32'(hang), 0);
    cyc(0, 0, 0, 0, 0);
    chk("hang_set", 32'(hang), 1);
    cyc(0, 0, 0, 0, 0);
    chk("hang_sticky", 32'(hang), 1);
    @(posedge clk);
    #1;
    rst_n = 0;
    @(negedge clk);
    chk("hang_rst", 32'(hang), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    // stall counter saturation
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 1);
    chk("if_stall", 32'(stall), 32'h03);
    cyc(0, 0, 0, 0, 0);
    chk("cnt_sat", 32'(cnt_s), 32'hF);
    // reset during PEND discards the held redirect
    cyc(1, 1, 32'h300, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("pend_before_rst", 32'(pend), 1);
    #2;
    rst_n = 0;
    smem = 0;
    #1;
    chk("pend_async_rst", 32'(pend), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc(0, 0, 0, 0, 0);
    chk("no_redirect_after_rst", 32'(redir), 0);
    cyc(0, 0, 0, 0, 0);
    chk("cnt_flush_after_rst", 32'(cnt_f), 0);
    // mixed traffic, checked by the model
    for (int i = 0; i < 80; i++)
      cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
          $urandom & 32'hFFFC, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
